// File: rtl/vga_sync_decoder.sv
// Recovers column/line position from a VGA sync stream, measures line and frame
// timing against the nominal mode, and passes RGB only while timing is locked.
module vga_sync_decoder #(
  parameter int TOTAL_WIDTH    = 800,  // clocks per line
  parameter int TOTAL_HEIGHT   = 525,  // lines per frame
  parameter int H_ACTIVE_START = 48,   // first active column
  parameter int ACTIVE_WIDTH   = 640,  // active columns per line
  parameter int V_ACTIVE_START = 33,   // first active line
  parameter int ACTIVE_HEIGHT  = 480,  // active lines per frame
  parameter int LOCK_FRAMES    = 2     // consecutive good frames needed for lock
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [2:0] i_Red,
  input  logic [2:0] i_Green,
  input  logic [2:0] i_Blue,
  output logic       o_Locked,
  output logic [9:0] o_HPos,
  output logic [9:0] o_VPos,
  output logic       o_Active,
  output logic [2:0] o_Red,
  output logic [2:0] o_Green,
  output logic [2:0] o_Blue,
  output logic       o_FrameStart,
  output logic       o_SyncError,
  output logic [9:0] o_LineLength,
  output logic [9:0] o_LineCount
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0] C_SAT    = 10'd1023;
  localparam logic [9:0] C_WIDTH  = 10'(TOTAL_WIDTH);
  localparam logic [9:0] C_HEIGHT = 10'(TOTAL_HEIGHT);
  localparam logic [9:0] C_HS     = 10'(H_ACTIVE_START);
  localparam logic [9:0] C_HE     = 10'(H_ACTIVE_START + ACTIVE_WIDTH);
  localparam logic [9:0] C_VS     = 10'(V_ACTIVE_START);
  localparam logic [9:0] C_VE     = 10'(V_ACTIVE_START + ACTIVE_HEIGHT);
  localparam logic [7:0] C_LOCK   = 8'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] x);
    return (x == C_SAT) ? C_SAT : x + 10'd1;
  endfunction

  logic       r_HSync_p0, r_VSync_p0;
  logic       r_HSync_p1, r_VSync_p1;
  logic [2:0] r_Red_p0, r_Green_p0, r_Blue_p0;
  logic [9:0] r_Col, r_Line;
  logic [7:0] r_Good;
  state_t     r_State;

  // Stage 0: input capture plus one-sample sync history for edge detection
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_HSync_p0 <= 1'b0;
      r_VSync_p0 <= 1'b0;
      r_HSync_p1 <= 1'b0;
      r_VSync_p1 <= 1'b0;
      r_Red_p0   <= 3'd0;
      r_Green_p0 <= 3'd0;
      r_Blue_p0  <= 3'd0;
    end else begin
      r_HSync_p0 <= i_HSync;
      r_VSync_p0 <= i_VSync;
      r_HSync_p1 <= r_HSync_p0;
      r_VSync_p1 <= r_VSync_p0;
      r_Red_p0   <= i_Red;
      r_Green_p0 <= i_Green;
      r_Blue_p0  <= i_Blue;
    end
  end

  logic       w_HRise, w_VRise;
  logic [9:0] w_ColInc, w_LineInc, w_Col, w_Line;
  logic       w_LineBad, w_FrameBad, w_Viol;
  logic [7:0] w_GoodInc;
  logic       w_LockNext, w_InH, w_InV, w_Active;

  assign w_HRise   = r_HSync_p0 & ~r_HSync_p1;
  assign w_VRise   = r_VSync_p0 & ~r_VSync_p1;
  assign w_ColInc  = sat_inc(r_Col);
  assign w_LineInc = sat_inc(r_Line);
  assign w_Col     = w_HRise ? 10'd0 : w_ColInc;
  assign w_Line    = w_VRise ? 10'd0 : (w_HRise ? w_LineInc : r_Line);

  // A runaway line is flagged once, on the sample where the counter first saturates
  assign w_LineBad  = w_HRise ? (w_ColInc != C_WIDTH) : (r_Col == C_SAT - 10'd1);
  assign w_FrameBad = w_VRise && (w_LineInc != C_HEIGHT);
  assign w_Viol     = w_LineBad || w_FrameBad;
  assign w_GoodInc  = r_Good + 8'd1;

  assign w_LockNext = !w_Viol && ((r_State == LOCKED) ||
                      ((r_State == ACQUIRE) && w_VRise && (w_GoodInc == C_LOCK)));
  assign w_InH      = (w_Col >= C_HS) && (w_Col < C_HE);
  assign w_InV      = (w_Line >= C_VS) && (w_Line < C_VE);
  assign w_Active   = w_LockNext && w_InH && w_InV;

  // Stage 1: position counters, timing measurement, lock FSM and outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Col        <= 10'd0;
      r_Line       <= 10'd0;
      r_Good       <= 8'd0;
      r_State      <= SEARCH;
      o_Locked     <= 1'b0;
      o_HPos       <= 10'd0;
      o_VPos       <= 10'd0;
      o_Active     <= 1'b0;
      o_Red        <= 3'd0;
      o_Green      <= 3'd0;
      o_Blue       <= 3'd0;
      o_FrameStart <= 1'b0;
      o_SyncError  <= 1'b0;
      o_LineLength <= 10'd0;
      o_LineCount  <= 10'd0;
    end else begin
      r_Col  <= w_Col;
      r_Line <= w_Line;
      if (w_HRise) o_LineLength <= w_ColInc;
      if (w_VRise) o_LineCount  <= w_LineInc;

      case (r_State)
        SEARCH: begin
          if (w_VRise) begin
            r_State <= ACQUIRE;
            r_Good  <= 8'd0;
          end
        end
        ACQUIRE: begin
          if (w_Viol) begin
            r_State <= SEARCH;
          end else if (w_VRise) begin
            r_Good <= w_GoodInc;
            if (w_GoodInc == C_LOCK) r_State <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_Viol) r_State <= SEARCH;
        end
        default: r_State <= SEARCH;
      endcase

      o_Locked     <= w_LockNext;
      o_SyncError  <= w_Viol && (r_State != SEARCH);
      o_FrameStart <= w_VRise;
      o_Active     <= w_Active;
      o_HPos       <= w_Active ? (w_Col - C_HS) : 10'd0;
      o_VPos       <= w_Active ? (w_Line - C_VS) : 10'd0;
      o_Red        <= w_Active ? r_Red_p0 : 3'd0;
      o_Green      <= w_Active ? r_Green_p0 : 3'd0;
      o_Blue       <= w_Active ? r_Blue_p0 : 3'd0;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 40x24 mode; expected outputs per
// sample are queued at drive time and compared when they emerge 2 clocks later.
`timescale 1ns/1ps
module tb_vga_sync_decoder;

  localparam int W   = 40;
  localparam int H   = 24;
  localparam int HAS = 6;
  localparam int AW  = 28;
  localparam int VAS = 3;
  localparam int AH  = 18;

  logic       i_Clk = 1'b0, i_Rst = 1'b0, i_HSync = 1'b0, i_VSync = 1'b0;
  logic [2:0] i_Red = 3'd0, i_Green = 3'd0, i_Blue = 3'd0;
  logic       o_Locked, o_Active, o_FrameStart, o_SyncError;
  logic [9:0] o_HPos, o_VPos, o_LineLength, o_LineCount;
  logic [2:0] o_Red, o_Green, o_Blue;

  typedef struct packed {
    logic       lk;
    logic       act;
    logic [9:0] hp;
    logic [9:0] vp;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic       fs;
    logic       err;
  } obs_t;

  obs_t sb[$];
  obs_t exp_o;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 i_Clk = ~i_Clk;

  vga_sync_decoder #(
    .TOTAL_WIDTH(W), .TOTAL_HEIGHT(H), .H_ACTIVE_START(HAS), .ACTIVE_WIDTH(AW),
    .V_ACTIVE_START(VAS), .ACTIVE_HEIGHT(AH), .LOCK_FRAMES(2)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Green(i_Green), .i_Blue(i_Blue),
    .o_Locked(o_Locked), .o_HPos(o_HPos), .o_VPos(o_VPos), .o_Active(o_Active),
    .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue),
    .o_FrameStart(o_FrameStart), .o_SyncError(o_SyncError),
    .o_LineLength(o_LineLength), .o_LineCount(o_LineCount)
  );

  function automatic obs_t observe();
    return {o_Locked, o_Active, o_HPos, o_VPos, o_Red, o_Green, o_Blue, o_FrameStart, o_SyncError};
  endfunction

  // Drive one sample at column c of line ln (line has nc clocks, frame nl lines)
  // and queue what the outputs must show for it.
  task automatic px(input int c, input int ln, input int nc, input int nl,
                    input logic lk, input logic err);
    obs_t e;
    logic [2:0] r, g, b;
    logic act;
    r = 3'($urandom);
    g = 3'($urandom);
    b = 3'($urandom);
    if (c == HAS && ln == VAS) begin
      r = 3'b111; g = 3'b100; b = 3'b000;
    end
    i_HSync = !(c >= nc - 4);
    i_VSync = !(ln >= nl - 2);
    i_Red = r; i_Green = g; i_Blue = b;
    act   = lk && (c >= HAS) && (c < HAS + AW) && (ln >= VAS) && (ln < VAS + AH);
    e.lk  = lk;
    e.act = act;
    e.hp  = act ? 10'(c - HAS) : 10'd0;
    e.vp  = act ? 10'(ln - VAS) : 10'd0;
    e.r   = act ? r : 3'd0;
    e.g   = act ? g : 3'd0;
    e.b   = act ? b : 3'd0;
    e.fs  = (c == 0) && (ln == 0);
    e.err = err;
    sb.push_back(e);
    @(posedge i_Clk);
    #1;
    while (sb.size() > 2) void'(sb.pop_front());
  endtask

  task automatic reset_dut();
    i_Rst = 1'b1;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    sb.delete();
  endtask

  // Two good frames from reset; the next frame start is the lock point.
  task automatic lock_up();
    reset_dut();
    for (int f = 0; f < 2; f++)
      for (int ln = 0; ln < H; ln++)
        for (int c = 0; c < W; c++)
          px(c, ln, W, H, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    i_Rst = 1'b0;
    #1;
    i_Rst = 1'b1;
    #1;
    n_cmp++;
    if (observe() !== obs_t'(0)) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", observe());
    end
    n_cmp++;
    if ({o_LineLength, o_LineCount} !== 20'd0) begin
      n_bad++; $display("FAIL reset_measure got=%0d/%0d exp=0/0", o_LineLength, o_LineCount);
    end
    reset_dut();
  endtask

  task automatic test_lock();
    reset_dut();
    for (int f = 0; f < 4; f++)
      for (int ln = 0; ln < H; ln++)
        for (int c = 0; c < W; c++) begin
          px(c, ln, W, H, f >= 2, 1'b0);
          if (sb.size() == 2) begin
            exp_o = sb.pop_front(); n_cmp++;
            if (observe() !== exp_o) begin
              n_bad++; $display("FAIL lock f=%0d l=%0d c=%0d got=%h exp=%h", f, ln, c, observe(), exp_o);
            end
          end
        end
    n_cmp++;
    if (o_LineLength !== 10'd40) begin
      n_bad++; $display("FAIL lock_linelen got=%0d exp=40", o_LineLength);
    end
    n_cmp++;
    if (o_LineCount !== 10'd24) begin
      n_bad++; $display("FAIL lock_linecount got=%0d exp=24", o_LineCount);
    end
  endtask

  task automatic test_active_rgb();
    for (int ln = 0; ln <= VAS; ln++)
      for (int c = 0; c < ((ln == VAS) ? HAS + 2 : W); c++) begin
        px(c, ln, W, H, 1'b1, 1'b0);
        if (sb.size() == 2) begin
          exp_o = sb.pop_front(); n_cmp++;
          if (observe() !== exp_o) begin
            n_bad++; $display("FAIL active l=%0d c=%0d got=%h exp=%h", ln, c, observe(), exp_o);
          end
        end
      end
    n_cmp++;
    if ({o_Active, o_HPos, o_VPos, o_Red, o_Green, o_Blue} !==
        {1'b1, 10'd0, 10'd0, 3'b111, 3'b100, 3'b000}) begin
      n_bad++;
      $display("FAIL first_pixel got act=%b h=%0d v=%0d rgb=%b/%b/%b exp act=1 h=0 v=0 rgb=111/100/000",
               o_Active, o_HPos, o_VPos, o_Red, o_Green, o_Blue);
    end
  endtask

  task automatic test_short_line();
    lock_up();
    for (int f = 0; f < 4; f++)
      for (int ln = 0; ln < ((f == 3) ? 2 : H); ln++)
        for (int c = 0; c < ((f == 0 && ln == 5) ? W - 1 : W); c++) begin
          logic lk;
          lk = (f == 0) ? (ln < 6) : (f == 3);
          px(c, ln, (f == 0 && ln == 5) ? W - 1 : W, H, lk, f == 0 && ln == 6 && c == 0);
          if (sb.size() == 2) begin
            exp_o = sb.pop_front(); n_cmp++;
            if (observe() !== exp_o) begin
              n_bad++; $display("FAIL short_line f=%0d l=%0d c=%0d got=%h exp=%h", f, ln, c, observe(), exp_o);
            end
          end
          if (f == 0 && ln == 6 && c == 2) begin
            n_cmp++;
            if (o_LineLength !== 10'd39) begin
              n_bad++; $display("FAIL short_linelen got=%0d exp=39", o_LineLength);
            end
          end
        end
  endtask

  task automatic test_missing_hsync();
    lock_up();
    for (int f = 0; f < 2; f++)
      for (int ln = 0; ln < ((f == 1) ? 2 : H); ln++)
        for (int c = 0; c < ((f == 0 && ln == 5) ? 1100 : W); c++) begin
          logic lk;
          lk = (f == 0) && ((ln < 5) || (ln == 5 && c < 1023));
          px(c, ln, (f == 0 && ln == 5) ? 1100 : W, H, lk, f == 0 && ln == 5 && c == 1023);
          if (sb.size() == 2) begin
            exp_o = sb.pop_front(); n_cmp++;
            if (observe() !== exp_o) begin
              n_bad++; $display("FAIL no_hsync f=%0d l=%0d c=%0d got=%h exp=%h", f, ln, c, observe(), exp_o);
            end
          end
          if (f == 0 && ln == 6 && c == 2) begin
            n_cmp++;
            if (o_LineLength !== 10'd1023) begin
              n_bad++; $display("FAIL no_hsync_linelen got=%0d exp=1023", o_LineLength);
            end
          end
        end
  endtask

  task automatic test_short_frame();
    lock_up();
    for (int f = 0; f < 2; f++)
      for (int ln = 0; ln < ((f == 1) ? 3 : H - 1); ln++)
        for (int c = 0; c < W; c++) begin
          px(c, ln, W, (f == 0) ? H - 1 : H, f == 0, f == 1 && ln == 0 && c == 0);
          if (sb.size() == 2) begin
            exp_o = sb.pop_front(); n_cmp++;
            if (observe() !== exp_o) begin
              n_bad++; $display("FAIL short_frame f=%0d l=%0d c=%0d got=%h exp=%h", f, ln, c, observe(), exp_o);
            end
          end
        end
    n_cmp++;
    if (o_LineCount !== 10'd23) begin
      n_bad++; $display("FAIL short_frame_count got=%0d exp=23", o_LineCount);
    end
  endtask

  task automatic test_reset_midframe();
    lock_up();
    for (int ln = 0; ln <= 10; ln++)
      for (int c = 0; c < ((ln == 10) ? 12 : W); c++) begin
        px(c, ln, W, H, 1'b1, 1'b0);
        if (sb.size() == 2) begin
          exp_o = sb.pop_front(); n_cmp++;
          if (observe() !== exp_o) begin
            n_bad++; $display("FAIL pre_reset l=%0d c=%0d got=%h exp=%h", ln, c, observe(), exp_o);
          end
        end
      end
    #2;
    i_Rst = 1'b1;
    #1;
    n_cmp++;
    if (observe() !== obs_t'(0)) begin
      n_bad++; $display("FAIL midframe_reset got=%h exp=0", observe());
    end
    n_cmp++;
    if ({o_LineLength, o_LineCount} !== 20'd0) begin
      n_bad++; $display("FAIL midframe_measure got=%0d/%0d exp=0/0", o_LineLength, o_LineCount);
    end
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    sb.delete();
    for (int f = 0; f < 3; f++)
      for (int ln = 0; ln < ((f == 2) ? 2 : H); ln++)
        for (int c = 0; c < W; c++) begin
          px(c, ln, W, H, f == 2, 1'b0);
          if (sb.size() == 2) begin
            exp_o = sb.pop_front(); n_cmp++;
            if (observe() !== exp_o) begin
              n_bad++; $display("FAIL relock f=%0d l=%0d c=%0d got=%h exp=%h", f, ln, c, observe(), exp_o);
            end
          end
        end
    n_cmp++;
    if (o_LineCount !== 10'd24) begin
      n_bad++; $display("FAIL relock_count got=%0d exp=24", o_LineCount);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active_rgb();
    test_short_line();
    test_missing_hsync();
    test_short_frame();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
